// File: rtl/div_sequencer.sv
// Radix-2 restoring divider with sequencing FSM for RV32M DIV/DIVU/REM/REMU.
// Stalls the pipeline while iterating and pulses result_valid in the release cycle.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            div_start,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall_pipl,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_quot, r_rem, r_divisor, r_result;
  logic            r_neg_q, r_neg_r, r_sel_rem;

  // Issue-side decode
  logic            w_start, w_signed, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_spec_res;

  assign w_start  = div_start & fun3[2] & ~flush;
  assign w_signed = ~fun3[0];
  assign w_a_neg  = w_signed & op_a[XLEN-1];
  assign w_b_neg  = w_signed & op_b[XLEN-1];
  assign w_abs_a  = w_a_neg ? -op_a : op_a;
  assign w_abs_b  = w_b_neg ? -op_b : op_b;

  assign w_div0    = (op_b == '0);
  assign w_ovf     = w_signed & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = fun3[1] ? op_a : '1;
    else
      w_spec_res = fun3[1] ? '0 : op_a;
  end

  // Restoring step. The shifted remainder can spill into bit XLEN when the
  // divisor is >= 2^(XLEN-1) (unsigned); a set spill bit always means "subtract".
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
  assign w_diff   = {1'b0, w_rem_sh[XLEN-1:0]} - {1'b0, r_divisor};
  assign w_ge     = w_rem_sh[XLEN] | ~w_diff[XLEN];

  // Sign fixup
  logic [XLEN-1:0] w_q_fix, w_r_fix;

  assign w_q_fix = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix = r_neg_r ? -r_rem  : r_rem;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_next = w_special ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == '0) w_next = S_FIXUP;
        S_FIXUP: w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    stall_pipl   = 1'b0;
    result_valid = 1'b0;
    if (reset_n && !flush) begin
      stall_pipl   = ((r_state == S_IDLE) & div_start & fun3[2]) |
                     (r_state == S_CALC) | (r_state == S_FIXUP);
      result_valid = (r_state == S_DONE);
    end
  end

  assign result = r_result;

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sel_rem <= fun3[1];
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_quot    <= w_abs_a;
            r_rem     <= '0;
            r_divisor <= w_abs_b;
            r_cnt     <= CW'(XLEN-1);
            if (w_special) r_result <= w_spec_res;
          end
        end
        S_CALC: begin
          r_quot <= {r_quot[XLEN-2:0], w_ge};
          r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIXUP: r_result <= r_sel_rem ? w_r_fix : w_q_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboarded results, stall/latency
// counts, special cases, flush, async reset and back-to-back issue.
module tb_div_sequencer;

  logic        clk, reset_n, div_start, flush;
  logic [2:0]  fun3;
  logic [31:0] op_a, op_b;
  logic        stall_pipl, result_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .div_start(div_start), .fun3(fun3),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall_pipl(stall_pipl),
    .result(result), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
      return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return f3[1] ? a % b : a / b;
  endfunction

  // Issue one divide, hold div_start through DONE, then verify no restart.
  task automatic do_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall, input string nm);
    int cyc, nstall;
    bit got;
    logic [31:0] want;
    @(posedge clk); #1;
    div_start = 1'b1; fun3 = f3; op_a = a; op_b = b;
    exp_q.push_back(exp);
    cyc = 0; nstall = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall_pipl) nstall++;
      if (result_valid) begin
        got = 1;
        want = exp_q.pop_front();
        checks++;
        if (result !== want) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", nm, result, want);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no result_valid within %0d cycles", nm, cyc);
      void'(exp_q.pop_front());
    end
    checks++;
    if (nstall != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", nm, nstall, exp_stall);
    end
    checks++;
    if (cyc != exp_stall + 1) begin
      errors++;
      $display("FAIL %s valid_cycle: got %0d expected %0d", nm, cyc, exp_stall + 1);
    end
    @(posedge clk); #1;
    div_start = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s no_restart: stall=%b valid=%b expected 0 0", nm, stall_pipl, result_valid);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; div_start = 1'b0; flush = 1'b0; fun3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_pipl !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: stall=%b valid=%b result=%h expected 0 0 0", stall_pipl, result_valid, result);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_divu_basic;
    do_div(F_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
  endtask

  task automatic test_signed;
    do_div(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    do_div(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    do_div(F_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         34, "remu_fff9_2");
    do_div(F_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
    do_div(F_REM,  32'd7, 32'hFFFF_FFFE, 32'd1,         34, "rem_7_m2");
    do_div(F_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34, "divu_big_divisor");
    do_div(F_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 34, "remu_big_divisor");
  endtask

  task automatic test_div_by_zero;
    do_div(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_div(F_REM,  32'd5, 32'd0, 32'd5,         1, "rem_by0");
  endtask

  task automatic test_overflow;
    do_div(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_div(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");
  endtask

  task automatic test_ignored_start;
    @(posedge clk); #1;
    div_start = 1'b1; fun3 = 3'b011; op_a = 32'd10; op_b = 32'd2;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start: stall=%b valid=%b expected 0 0", stall_pipl, result_valid);
      end
    end
    @(posedge clk); #1;
    div_start = 1'b0;
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    div_start = 1'b1; fun3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (stall_pipl !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: stall=%b expected 1", stall_pipl);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: stall=%b valid=%b expected 0 0", stall_pipl, result_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_with_start: stall=%b valid=%b expected 0 0", stall_pipl, result_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle: stall=%b valid=%b expected 0 0", stall_pipl, result_valid);
      end
    end
    do_div(F_DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_after_flush");
  endtask

  task automatic test_reset_mid_op;
    @(posedge clk); #1;
    div_start = 1'b1; fun3 = F_DIV; op_a = 32'd1000; op_b = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (stall_pipl !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op: stall=%b valid=%b result=%h expected 0 0 0", stall_pipl, result_valid, result);
    end
    @(posedge clk); #1;
    div_start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall_pipl !== 1'b0 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: stall=%b valid=%b expected 0 0", stall_pipl, result_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_div(F_DIV, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFF5, 34, "b2b_first");
    do_div(F_DIV, 32'd81, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 34, "b2b_second");
  endtask

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          spec;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      spec = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      do_div(f3, a, b, ref_div(f3, a, b), spec ? 1 : 34, "random");
    end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_div_by_zero;
    test_overflow;
    test_ignored_start;
    test_flush;
    test_reset_mid_op;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
